// File: rtl/ibuf_fetch_writer.sv
// Producer side of the instruction fetch RAM: issues 8-beat bus bursts at the
// fetch pointer and writes each returned word with per-byte 8086 predecode.
module ibuf_fetch_writer #(
  parameter int unsigned AW    = 20,
  parameter int unsigned BEATS = 8
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iReq,
  input  logic          iJumped,
  input  logic [AW-1:0] iJumpAdr,
  output logic          oRdReq,
  output logic [AW-1:0] oRdAdr,
  input  logic          iRdAck,
  input  logic          iRdValid,
  input  logic [63:0]   iRdData,
  output logic          oFWr,
  output logic [63:0]   oFData,
  output logic [23:0]   oFLen,
  output logic [23:0]   oFMod,
  output logic [1:0]    oMemIndex
);

  localparam int unsigned BW = $clog2(BEATS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] r_fptr;
  logic [BW-1:0] r_beat;
  logic          r_stale;
  logic          r_idx_pend;
  logic [1:0]    r_idx;

  logic          w_accept;
  logic          w_last_beat;
  logic          w_beat_stale;
  logic [AW-1:0] w_jump_adr;
  logic [23:0]   w_len;
  logic [23:0]   w_mod;

  function automatic logic f_has_modrm(input logic [7:0] b);
    return ((b[7:6] == 2'b00) && !b[2]) ||
           (b[7:4] == 4'h8) ||
           (b[7:2] == 6'b1100_01) ||
           (b[7:2] == 6'b1101_00) ||
           (b[7:3] == 5'b1101_1) ||
           (b[7:1] == 7'b1111_011) ||
           (b[7:1] == 7'b1111_111);
  endfunction

  // Displacement bytes implied if this byte were a ModRM byte.
  function automatic logic [1:0] f_disp(input logic [7:0] b);
    logic [1:0] d;
    d = 2'd0;
    case (b[7:6])
      2'b01:   d = 2'd1;
      2'b10:   d = 2'd2;
      2'b00:   d = (b[2:0] == 3'b110) ? 2'd2 : 2'd0;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] f_len(input logic [7:0] b);
    logic [2:0] l;
    l = f_has_modrm(b) ? 3'd2 : 3'd1;
    if ((b[7:6] == 2'b00) && (b[2:1] == 2'b10)) l = b[0] ? 3'd3 : 3'd2;
    if (b[7:1] == 7'b1010_100) l = b[0] ? 3'd3 : 3'd2;
    casez (b)
      8'h80, 8'h82, 8'h83, 8'hC6:              l = 3'd3;
      8'h81, 8'hC7:                            l = 3'd4;
      8'b0111_????, 8'b1110_0???, 8'hEB, 8'hCD: l = 3'd2;
      8'b1010_00??, 8'hE8, 8'hE9, 8'hC2, 8'hCA: l = 3'd3;
      8'h9A, 8'hEA:                            l = 3'd5;
      8'b1011_0???:                            l = 3'd2;
      8'b1011_1???:                            l = 3'd3;
      8'hD4, 8'hD5:                            l = 3'd2;
      default:                                 l = l;
    endcase
    return l;
  endfunction

  always_comb begin
    w_len = '0;
    w_mod = '0;
    for (int k = 0; k < 8; k++) begin
      w_len[3*k +: 3] = f_len(iRdData[8*k +: 8]);
      w_mod[3*k +: 3] = {f_has_modrm(iRdData[8*k +: 8]), f_disp(iRdData[8*k +: 8])};
    end
  end

  assign w_accept     = (r_state == S_DATA) && iRdValid;
  assign w_last_beat  = w_accept && (r_beat == BW'(BEATS - 1));
  assign w_beat_stale = r_stale || iJumped;
  assign w_jump_adr   = {iJumpAdr[AW-1:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iReq)        w_state_nxt = S_ADDR;
      S_ADDR:  if (iRdAck)      w_state_nxt = S_DATA;
      S_DATA:  if (w_last_beat) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Bus request and burst beat counting.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oRdReq <= 1'b0;
      oRdAdr <= '0;
      r_beat <= '0;
    end else begin
      if ((r_state == S_IDLE) && iReq) begin
        oRdReq <= 1'b1;
        oRdAdr <= iJumped ? w_jump_adr : r_fptr;
      end else if ((r_state == S_ADDR) && iRdAck) begin
        oRdReq <= 1'b0;
      end
      if ((r_state == S_ADDR) && iRdAck) r_beat <= '0;
      else if (w_accept)                r_beat <= r_beat + BW'(1);
    end
  end

  // Every accepted beat is written, stale or not; the consumer counts them.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oFWr      <= 1'b0;
      oFData    <= '0;
      oFLen     <= '0;
      oFMod     <= '0;
      oMemIndex <= '0;
    end else begin
      oFWr      <= w_accept;
      oMemIndex <= '0;
      if (w_accept) begin
        oFData <= iRdData;
        oFLen  <= w_len;
        oFMod  <= w_mod;
        if (!w_beat_stale && r_idx_pend) oMemIndex <= r_idx;
      end
    end
  end

  // Fetch pointer follows jumps; beats fetched before a jump do not advance it.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_fptr     <= '0;
      r_idx      <= '0;
      r_idx_pend <= 1'b0;
      r_stale    <= 1'b0;
    end else begin
      if (iJumped) begin
        r_fptr     <= w_jump_adr;
        r_idx      <= iJumpAdr[1:0];
        r_idx_pend <= 1'b1;
      end else if (w_accept && !r_stale) begin
        r_fptr     <= r_fptr + AW'(8);
        r_idx_pend <= 1'b0;
      end
      if (w_last_beat)                      r_stale <= 1'b0;
      else if (iJumped && (r_state != S_IDLE)) r_stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibuf_fetch_writer.sv
// Bench for ibuf_fetch_writer: predecode vector table, directed burst/jump/reset
// sequences and randomized bursts against a table-based reference model.
module tb_ibuf_fetch_writer;

  localparam int unsigned AW = 20;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iReq;
  logic          iJumped;
  logic [AW-1:0] iJumpAdr;
  logic          oRdReq;
  logic [AW-1:0] oRdAdr;
  logic          iRdAck;
  logic          iRdValid;
  logic [63:0]   iRdData;
  logic          oFWr;
  logic [63:0]   oFData;
  logic [23:0]   oFLen;
  logic [23:0]   oFMod;
  logic [1:0]    oMemIndex;

  ibuf_fetch_writer #(.AW(AW), .BEATS(8)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iJumped(iJumped), .iJumpAdr(iJumpAdr),
    .oRdReq(oRdReq), .oRdAdr(oRdAdr), .iRdAck(iRdAck), .iRdValid(iRdValid),
    .iRdData(iRdData), .oFWr(oFWr), .oFData(oFData), .oFLen(oFLen), .oFMod(oFMod),
    .oMemIndex(oMemIndex)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [63:0] d;
    logic [23:0] l;
    logic [23:0] m;
  } vec_t;

  typedef struct packed {
    logic [63:0] d;
    logic [23:0] l;
    logic [23:0] m;
    logic [1:0]  ix;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_vld = 1'b0;
  wr_t  exp_q[$];
  wr_t  m_e;
  vec_t tab[8];

  int   len_tab[256];
  bit   modrm_tab[256];
  logic [AW-1:0] m_fptr;
  logic          m_stale;
  logic          m_pend;
  logic [1:0]    m_idx;
  logic [AW-1:0] obs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [63:0] b8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [23:0] f3(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Reference predecode: opcode tables filled from range rules, later rules override.
  task automatic init_tabs();
    for (int b = 0; b < 256; b++) begin
      modrm_tab[b] = (b < 'h40 && (b & 4) == 0) || (b >= 'h80 && b <= 'h8F) ||
                     (b >= 'hC4 && b <= 'hC7) || (b >= 'hD0 && b <= 'hD3) ||
                     (b >= 'hD8 && b <= 'hDF) || b == 'hF6 || b == 'hF7 || b == 'hFE || b == 'hFF;
      len_tab[b] = modrm_tab[b] ? 2 : 1;
      if (b < 'h40 && (b % 8 == 4 || b % 8 == 5)) len_tab[b] = 2 + (b % 2);
      if (b == 'hA8 || b == 'hA9) len_tab[b] = 2 + (b % 2);
      if (b >= 'h70 && b <= 'h7F) len_tab[b] = 2;
      if (b >= 'hE0 && b <= 'hE7) len_tab[b] = 2;
      if (b >= 'hA0 && b <= 'hA3) len_tab[b] = 3;
      if (b >= 'hB0 && b <= 'hB7) len_tab[b] = 2;
      if (b >= 'hB8 && b <= 'hBF) len_tab[b] = 3;
    end
    len_tab['h80] = 3; len_tab['h82] = 3; len_tab['h83] = 3; len_tab['h81] = 4;
    len_tab['hC6] = 3; len_tab['hC7] = 4; len_tab['hEB] = 2; len_tab['hCD] = 2;
    len_tab['hE8] = 3; len_tab['hE9] = 3; len_tab['hC2] = 3; len_tab['hCA] = 3;
    len_tab['h9A] = 5; len_tab['hEA] = 5; len_tab['hD4] = 2; len_tab['hD5] = 2;
  endtask

  task automatic model_pre(input logic [63:0] d, output logic [23:0] l, output logic [23:0] m);
    int b, md, rm, dsp;
    l = '0;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      b   = int'(d[8*k +: 8]);
      md  = b / 64;
      rm  = b % 8;
      dsp = (md == 1) ? 1 : (md == 2) ? 2 : (md == 0 && rm == 6) ? 2 : 0;
      l[3*k +: 3] = 3'(len_tab[b]);
      m[3*k +: 3] = {modrm_tab[b], 2'(dsp)};
    end
  endtask

  task automatic model_jump(input logic [AW-1:0] adr, input logic in_burst);
    m_fptr = {adr[AW-1:2], 2'b00};
    m_idx  = adr[1:0];
    m_pend = 1'b1;
    if (in_burst) m_stale = 1'b1;
  endtask

  // Write monitor: each valid beat must produce exactly one write one cycle later.
  always @(negedge iClk) begin
    if (mon_en && (prev_vld || oFWr)) begin
      chk("fwr_timing", 64'(oFWr), 64'(prev_vld));
      if (oFWr) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fwr_extra actual=write required=none");
        end else begin
          m_e = exp_q.pop_front();
          chk("fdata", oFData, m_e.d);
          chk("flen", 64'(oFLen), 64'(m_e.l));
          chk("fmod", 64'(oFMod), 64'(m_e.m));
          chk("memindex", 64'(oMemIndex), 64'(m_e.ix));
        end
      end
    end
    prev_vld = iRdValid && mon_en;
  end

  task automatic jump_idle(input logic [AW-1:0] adr);
    model_jump(adr, 1'b0);
    iJumped = 1'b1; iJumpAdr = adr;
    tick();
    iJumped = 1'b0;
  endtask

  task automatic do_req(input logic jmp, input logic [AW-1:0] jadr, input int ack_lat,
                        output logic [AW-1:0] adr_seen);
    logic [AW-1:0] exp_adr;
    if (jmp) model_jump(jadr, 1'b0);
    exp_adr = m_fptr;
    iReq = 1'b1; iJumped = jmp; iJumpAdr = jadr;
    tick();
    iReq = 1'b0; iJumped = 1'b0;
    adr_seen = oRdAdr;
    chk("rdreq", 64'(oRdReq), 64'(1));
    chk("rdadr", 64'(oRdAdr), 64'(exp_adr));
    for (int i = 0; i < ack_lat; i++) begin
      tick();
      chk("rdreq_hold", 64'(oRdReq), 64'(1));
      chk("rdadr_hold", 64'(oRdAdr), 64'(exp_adr));
    end
    iRdAck = 1'b1;
    tick();
    iRdAck = 1'b0;
    chk("rdreq_drop", 64'(oRdReq), 64'(0));
  endtask

  // jmode 0: no jump; 1: jump on a spare cycle before beat jb; 2: jump with beat jb.
  task automatic do_beats(input int jmode, input int jb, input logic [AW-1:0] jadr,
                          input int gmax, input logic use_tab);
    int c0, g;
    logic [63:0] dat;
    logic [23:0] el, em;
    logic [1:0]  ix;
    logic        st, jw;
    c0 = wr_cnt;
    for (int b = 0; b < 8; b++) begin
      if (jmode == 1 && b == jb) begin
        model_jump(jadr, 1'b1);
        iJumped = 1'b1; iJumpAdr = jadr;
        tick();
        iJumped = 1'b0;
      end
      g = int'($urandom_range(gmax, 0));
      for (int i = 0; i < g; i++) tick();
      dat = use_tab ? tab[b].d : {$urandom, $urandom};
      if (use_tab) begin el = tab[b].l; em = tab[b].m; end
      else model_pre(dat, el, em);
      jw = (jmode == 2 && b == jb);
      st = m_stale || jw;
      ix = (!st && m_pend) ? m_idx : 2'd0;
      if (!st) begin
        m_pend = 1'b0;
        m_fptr = m_fptr + AW'(8);
      end
      if (jw) model_jump(jadr, 1'b1);
      exp_q.push_back('{d: dat, l: el, m: em, ix: ix});
      iRdValid = 1'b1; iRdData = dat; iJumped = jw; iJumpAdr = jadr;
      tick();
      iRdValid = 1'b0; iJumped = 1'b0;
    end
    m_stale = 1'b0;
    tick();
    tick();
    chk("burst_writes", 64'(wr_cnt - c0), 64'(8));
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    init_tabs();
    tab[0] = '{b8(8'h83, 8'hC0, 8'h05, 8'hB8, 8'h34, 8'h12, 8'hF7, 8'h06),
               f3(3, 1, 3, 3, 2, 2, 2, 1), f3(6, 0, 0, 2, 0, 4, 4, 2)};
    tab[1] = '{b8(8'h80, 8'h81, 8'h82, 8'hC6, 8'hC7, 8'hEB, 8'h9A, 8'hEA),
               f3(3, 4, 3, 3, 4, 2, 5, 5), f3(6, 6, 6, 4, 4, 0, 2, 0)};
    tab[2] = '{b8(8'h70, 8'h7F, 8'hE0, 8'hE3, 8'hCD, 8'hE4, 8'hE7, 8'hD4),
               f3(2, 2, 2, 2, 2, 2, 2, 2), f3(1, 1, 0, 0, 0, 0, 0, 0)};
    tab[3] = '{b8(8'hA0, 8'hA3, 8'hE8, 8'hE9, 8'hC2, 8'hCA, 8'hB0, 8'hBF),
               f3(3, 3, 3, 3, 3, 3, 2, 3), f3(2, 2, 0, 0, 0, 0, 2, 2)};
    tab[4] = '{b8(8'h04, 8'h05, 8'h3C, 8'h3D, 8'hD5, 8'hD0, 8'hD8, 8'hFE),
               f3(2, 3, 2, 3, 2, 2, 2, 2), f3(0, 0, 0, 0, 0, 4, 4, 4)};
    tab[5] = '{b8(8'h00, 8'h3B, 8'h8F, 8'hC4, 8'hC5, 8'hF6, 8'hFF, 8'h90),
               f3(2, 2, 2, 2, 2, 2, 2, 1), f3(4, 4, 6, 4, 4, 4, 4, 2)};
    tab[6] = '{b8(8'h46, 8'h0E, 8'h42, 8'h81, 8'h40, 8'h24, 8'hC3, 8'h8B),
               f3(1, 1, 1, 4, 1, 2, 1, 2), f3(1, 2, 1, 6, 1, 0, 0, 6)};
    tab[7] = '{b8(8'h86, 8'h06, 8'hFF, 8'h0F, 8'hF5, 8'hCC, 8'h9B, 8'h8E),
               f3(2, 1, 2, 1, 1, 1, 1, 2), f3(6, 2, 4, 0, 0, 0, 2, 6)};

    iRst = 1'b1; iReq = 1'b0; iJumped = 1'b0; iJumpAdr = '0;
    iRdAck = 1'b0; iRdValid = 1'b0; iRdData = '0;
    m_fptr = '0; m_stale = 1'b0; m_pend = 1'b0; m_idx = '0;
    tick();
    tick();
    chk("rst_rdreq", 64'(oRdReq), 64'(0));
    chk("rst_rdadr", 64'(oRdAdr), 64'(0));
    chk("rst_fwr", 64'(oFWr), 64'(0));
    chk("rst_fdata", oFData, 64'(0));
    chk("rst_memindex", 64'(oMemIndex), 64'(0));
    iRst = 1'b0;
    tick();
    mon_en = 1'b1;

    // First burst from address 0, then the next one 64 bytes on.
    do_req(1'b0, '0, 2, obs);
    chk("first_adr", 64'(obs), 64'(20'h00000));
    do_beats(0, 0, '0, 0, 1'b0);
    do_req(1'b0, '0, 0, obs);
    chk("second_adr", 64'(obs), 64'(20'h00040));
    do_beats(0, 0, '0, 1, 1'b0);

    // Jump in IDLE with byte offset 1, then a burst of predecode vectors.
    jump_idle(20'h12345);
    do_req(1'b0, '0, 1, obs);
    chk("jump_adr", 64'(obs), 64'(20'h12344));
    do_beats(0, 0, '0, 0, 1'b1);

    // Jump after beat 3: remaining beats are stale but still written.
    do_req(1'b0, '0, 0, obs);
    do_beats(1, 4, 20'h0A008, 0, 1'b0);
    do_req(1'b0, '0, 0, obs);
    chk("post_jump_adr", 64'(obs), 64'(20'h0A008));
    do_beats(2, 7, 20'h0B00E, 1, 1'b0);

    // Address wrap at the top of the physical space.
    jump_idle(20'hFFFF8);
    do_req(1'b0, '0, 0, obs);
    chk("wrap_start", 64'(obs), 64'(20'hFFFF8));
    do_beats(0, 0, '0, 0, 1'b0);
    do_req(1'b0, '0, 0, obs);
    chk("wrap_next", 64'(obs), 64'(20'h00038));
    do_beats(0, 0, '0, 0, 1'b0);

    // Jump coincident with request uses the new target.
    do_req(1'b1, 20'h54323, 1, obs);
    chk("jump_req_adr", 64'(obs), 64'(20'h54320));
    do_beats(0, 0, '0, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int r, jm;
      r  = int'($urandom_range(9, 0));
      jm = int'($urandom_range(3, 0));
      if (jm == 3) jm = 0;
      if (r == 0) jump_idle(AW'($urandom));
      do_req(r == 1, AW'($urandom), int'($urandom_range(3, 0)), obs);
      do_beats(jm, int'($urandom_range(7, 0)), AW'($urandom), 2, 1'b0);
    end

    // Asynchronous reset in the middle of a burst.
    do_req(1'b0, '0, 0, obs);
    mon_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      iRdValid = 1'b1; iRdData = {$urandom, $urandom} | 64'h1;
      tick();
    end
    iRdValid = 1'b0;
    #2 iRst = 1'b1;
    #1;
    chk("arst_rdreq", 64'(oRdReq), 64'(0));
    chk("arst_rdadr", 64'(oRdAdr), 64'(0));
    chk("arst_fwr", 64'(oFWr), 64'(0));
    chk("arst_fdata", oFData, 64'(0));
    chk("arst_flen", 64'(oFLen), 64'(0));
    chk("arst_fmod", 64'(oFMod), 64'(0));
    chk("arst_memindex", 64'(oMemIndex), 64'(0));
    #2 iRst = 1'b0;
    exp_q.delete();
    m_fptr = '0; m_stale = 1'b0; m_pend = 1'b0; m_idx = '0;
    tick();
    mon_en = 1'b1;
    do_req(1'b0, '0, 0, obs);
    chk("post_rst_adr", 64'(obs), 64'(20'h00000));
    do_beats(0, 0, '0, 1, 1'b0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
